// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes and helpers shared by the game control and debug decoding
package jogo_pkg;
    // Encodings double as the hexa7seg debug code
    typedef enum logic [3:0] {
        OCIOSO      = 4'h0,
        FILTRANDO   = 4'h1,
        VALIDA      = 4'h2,
        PRESSIONADA = 4'h3,
        SOLTANDO    = 4'h4,
        ERRO        = 4'hE
    } estado_t;

    // True when exactly one bit is set; callers zero-extend narrower buses
    function automatic logic um_quente(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction
endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for an asynchronous bus
//   clock, reset : system clock, asynchronous active-high reset
//   d            : asynchronous input bus
//   q            : second-stage synchronized bus
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);
    logic [LARGURA-1:0] meta;

    always_ff @(posedge clock or posedge reset)
        if (reset) {q, meta} <= '0;
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/condicionador_jogada.sv
// condicionador_jogada: synchronizes, debounces and one-hot checks the play keys
//   clock, reset    : system clock, asynchronous active-high reset
//   chaves_brutas   : raw switch levels
//   habilita        : allows a new press to start filtering (sampled only when idle)
//   chaves_limpas   : debounced one-hot key, held while the valid press lasts
//   jogada_valida   : one-cycle pulse on an accepted one-hot press
//   jogada_invalida : one-cycle pulse on an accepted non-one-hot pattern
//   db_estado       : FSM state code
//   db_tem_jogada   : high while a valid press is held
import jogo_pkg::*;

module condicionador_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int N_CHAVES        = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_CHAVES-1:0] chaves_brutas,
    input  logic                habilita,
    output logic [N_CHAVES-1:0] chaves_limpas,
    output logic                jogada_valida,
    output logic                jogada_invalida,
    output logic [3:0]          db_estado,
    output logic                db_tem_jogada
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] ALVO = CW'(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] UM = CW'(1);

    estado_t estado, prox;
    logic [N_CHAVES-1:0] amostra, candidato, cand_prox, limpas_prox;
    logic [CW-1:0] cnt, cnt_prox, inc;
    logic candidato_ok;

    sincronizador_2ff #(.LARGURA(N_CHAVES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (chaves_brutas),
        .q     (amostra)
    );

    // Saturates at the target so the counter can never wrap
    assign inc = (cnt >= ALVO) ? ALVO : cnt + UM;
    assign candidato_ok = um_quente(32'(candidato));

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            estado        <= OCIOSO;
            cnt           <= '0;
            candidato     <= '0;
            chaves_limpas <= '0;
        end else begin
            estado        <= prox;
            cnt           <= cnt_prox;
            candidato     <= cand_prox;
            chaves_limpas <= limpas_prox;
        end

    always_comb begin
        prox        = estado;
        cnt_prox    = cnt;
        cand_prox   = candidato;
        limpas_prox = chaves_limpas;
        case (estado)
            OCIOSO:
                if (amostra != '0 && habilita) begin
                    prox      = FILTRANDO;
                    cand_prox = amostra;
                    cnt_prox  = UM;
                end
            FILTRANDO:
                if (amostra == '0) prox = OCIOSO;
                else if (amostra != candidato) begin
                    cand_prox = amostra;
                    cnt_prox  = UM;
                end else if (cnt == ALVO) prox = VALIDA;
                else cnt_prox = inc;
            VALIDA: begin
                prox        = candidato_ok ? PRESSIONADA : ERRO;
                limpas_prox = candidato_ok ? candidato : '0;
                cnt_prox    = '0;
            end
            // Extra keys pressed on top of the held one are ignored until full release
            PRESSIONADA:
                if (amostra == '0) begin
                    prox     = SOLTANDO;
                    cnt_prox = UM;
                end
            SOLTANDO:
                if (amostra != '0) prox = PRESSIONADA;
                else if (inc == ALVO) begin
                    prox        = OCIOSO;
                    limpas_prox = '0;
                    cnt_prox    = '0;
                end else cnt_prox = inc;
            // Counts consecutive all-released samples; any key restarts the count
            ERRO: begin
                limpas_prox = '0;
                if (amostra != '0) cnt_prox = '0;
                else if (inc == ALVO) begin
                    prox     = OCIOSO;
                    cnt_prox = '0;
                end else cnt_prox = inc;
            end
            default: begin
                prox        = OCIOSO;
                limpas_prox = '0;
                cnt_prox    = '0;
            end
        endcase
    end

    // Pulses decode the single-cycle VALIDA state, so they are exclusive and one cycle wide
    assign jogada_valida   = (estado == VALIDA) && candidato_ok;
    assign jogada_invalida = (estado == VALIDA) && !candidato_ok;
    assign db_estado       = estado;
    assign db_tem_jogada   = (estado == PRESSIONADA);
endmodule
